divider_8b_seq: RTL and testbench



---
 rtl/divider_pkg.sv | 16 +
 rtl/div_step.sv | 28 ++
 rtl/divider_8b_seq.sv | 148 ++++++++++++++
 tb/tb_divider_8b_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding, default operand widths and the step counter width.
// Optional feature elsewhere in the slice: DIVIDER_EARLY_OUT_EN.
package divider_pkg;

    localparam int DW_DEF = 8;                 // dividend / quotient width
    localparam int VW_DEF = 4;                 // divisor / remainder width
    localparam int CNT_W  = $clog2(DW_DEF);    // step counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is registered.
module div_step
    import divider_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic [VW:0]   rem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] dvs_i,
    output logic [VW:0]   rem_o,
    output logic          q_o
);

    logic [VW+1:0] shifted;
    logic [VW+2:0] diff;

    // Shift the next bit in, then subtract with one spare bit so the sign is visible.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = {1'b0, shifted} - (VW+3)'(dvs_i);
        q_o     = ~diff[VW+2];
        // The incoming remainder is always below the divisor, so the kept value fits VW+1 bits.
        rem_o   = q_o ? (VW+1)'(diff) : (VW+1)'(shifted);
    end

endmodule

// File: rtl/divider_8b_seq.sv
// Sequential restoring divider (DW-bit dividend / VW-bit divisor), one quotient bit per cycle.
// Latency: out_valid rises DW+1 edges after accept (1 edge for early-out cases with DIVIDER_EARLY_OUT_EN).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE and never while rst is high.
module divider_8b_seq
    import divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;      // dividend, rotated left once per step
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW:0]   rem_q, rem_d;      // partial remainder
    logic [DW-1:0] quo_q, quo_d;      // quotient shift register
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          div_zero_q, div_zero_d;
    logic          out_valid_q, out_valid_d;

    logic [VW:0]   step_rem;
    logic          step_q;
    logic          dvs_zero;

`ifdef DIVIDER_EARLY_OUT_EN
    logic          early_hit;
    assign early_hit = (divisor == '0) || (dividend < DW'(divisor));
`endif

    assign dvs_zero  = (dvs_q == '0);
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

    // Single shared step unit, fed MSB-first from the rotating dividend register.
    div_step #(.VW(VW)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[DW-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DIVIDER_EARLY_OUT_EN
                    // Quotient is zero and the dividend is already the remainder.
                    if (early_hit) begin
                        rem_d   = {1'b0, dividend[VW-1:0]};
                        state_d = DONE;
                    end
`endif
                end
            end

            RUN: begin
                rem_d = step_rem;
                quo_d = {quo_q[DW-2:0], step_q};
                // After DW rotations the dividend register is back to its original value.
                dvd_d = {dvd_q[DW-2:0], dvd_q[DW-1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (!out_valid_q) begin
                    // First DONE cycle: publish the result, forcing the divide-by-zero pattern.
                    out_valid_d = 1'b1;
                    div_zero_d  = dvs_zero;
                    quotient_d  = dvs_zero ? '1 : quo_q;
                    remainder_d = dvs_zero ? dvd_q[VW-1:0] : VW'(rem_q);
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_divider_8b_seq.sv
// Self-checking bench for divider_8b_seq against a plain arithmetic reference.
// Directed cases from the test plan followed by the full product sweep and random operands.
// Honours DIVIDER_EARLY_OUT_EN when computing expected latency.
module tb_divider_8b_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int total = 0;
    int bad   = 0;

    divider_8b_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: {div_zero, quotient, remainder}.
    function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] q;
        logic [7:0] r;
        if (b == 4'd0) return {1'b1, 8'hFF, a[3:0]};
        q = a / {4'd0, b};
        r = a % {4'd0, b};
        return {1'b0, q, r[3:0]};
    endfunction

    function automatic int exp_lat(input logic [7:0] a, input logic [3:0] b);
`ifdef DIVIDER_EARLY_OUT_EN
        if (b == 4'd0 || a < {4'd0, b}) return 1;
`endif
        return 9;
    endfunction

    // One full transaction: accept, wait for result, optional back-pressure, handshake.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int hold, input bit poke);
        logic [12:0] e;
        int          lat;
        logic [7:0]  q0;
        logic [3:0]  r0;
        logic        z0;
        e = model(a, b);
        check("rdy_before_accept", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        lat = 0;
        while (!out_valid && lat < 40) begin
            check("rdy_busy", in_ready, 0);
            if (poke) begin
                in_valid = lat[0];
                dividend = 8'($urandom);
                divisor  = 4'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, exp_lat(a, b));
        check("quotient", quotient, e[11:4]);
        check("remainder", remainder, e[3:0]);
        check("div_zero", div_zero, e[12]);
        q0 = quotient;
        r0 = remainder;
        z0 = div_zero;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_quot", quotient, q0);
            check("bp_rem", remainder, r0);
            check("bp_dz", div_zero, z0);
            check("bp_rdy", in_ready, 0);
        end
        check("rdy_in_done", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_valid_low", out_valid, 0);
        check("hs_rdy_high", in_ready, 1);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_div_zero", div_zero, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_rdy", in_ready, 1);

        // Directed cases.
        run_op(8'd225, 4'd15, 0, 1'b0);
        run_op(8'd200, 4'd7, 0, 1'b1);
        run_op(8'd255, 4'd1, 0, 1'b0);
        run_op(8'd3, 4'd9, 0, 1'b0);
        run_op(8'hA7, 4'd0, 0, 1'b0);
        run_op(8'd100, 4'd6, 5, 1'b0);

        // Reset in the middle of RUN.
        dividend = 8'd100;
        divisor  = 4'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_quot", quotient, 0);
        check("mid_rst_rem", remainder, 0);
        check("mid_rst_dz", div_zero, 0);
        check("mid_rst_rdy", in_ready, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_release_rdy", in_ready, 1);

        // Round trip: (x*y)/y == x, remainder 0.
        for (int x = 1; x <= 15; x++) begin
            for (int y = 1; y <= 15; y++) begin
                run_op(8'(x * y), 4'(y), 0, 1'b0);
            end
        end

        // Random operands with random back-pressure and busy-time pokes.
        for (int k = 0; k < 40; k++) begin
            run_op(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
